// File: rtl/hack_cpu_wait.sv
// hack_cpu_wait: parametrised Hack CPU with memory wait-state handshake, wait timeout and halt detection.
// Optional HACK_CPU_PERF_EN adds perf_retired / perf_stall counters. Rev 1.0
`default_nettype none

module hack_cpu_wait #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int PC_W     = 15,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] inM,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic              readM,
  output logic [ADDR_W-1:0] addressM,
  output logic [PC_W-1:0]   pc,
  output logic              stall,
  output logic              halted,
  output logic              fault
`ifdef HACK_CPU_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] a_q, d_q;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fault_q, halted_q;

  logic [DATA_W-1:0] a_d, d_d;
  logic [PC_W-1:0]   pc_d;

  logic              is_c, a_bit, mem_req, retire, self_jump, take, zr, ng, active;
  logic [DATA_W-1:0] x0, x1, y0, y1, f_out, alu_out;
  logic [PC_W-1:0]   a_tgt;

  assign is_c  = instruction[15];
  assign a_bit = instruction[12];
  assign a_tgt = a_q[PC_W-1:0];

  always_comb begin
    x0      = instruction[11] ? '0 : d_q;
    x1      = instruction[10] ? ~x0 : x0;
    y0      = instruction[9] ? '0 : (a_bit ? inM : a_q);
    y1      = instruction[8] ? ~y0 : y0;
    f_out   = instruction[7] ? (x1 + y1) : (x1 & y1);
    alu_out = instruction[6] ? ~f_out : f_out;
  end

  assign zr   = (alu_out == '0);
  assign ng   = alu_out[DATA_W-1];
  assign take = is_c & ((instruction[2] & ng) | (instruction[1] & zr) |
                        (instruction[0] & ~ng & ~zr));

  // Self-jump is an unconditional jump whose target is the current instruction.
  assign self_jump = is_c & (&instruction[2:0]) & (a_tgt == pc_q);

  assign mem_req = is_c & (a_bit | instruction[3]);
  assign retire  = ((state_q == S_RUN) & (~mem_req | mem_ack)) |
                   ((state_q == S_WAIT) & mem_ack);

  always_comb begin
    a_d  = is_c ? (instruction[5] ? alu_out : a_q)
                : {{(DATA_W-15){1'b0}}, instruction[14:0]};
    d_d  = (is_c & instruction[4]) ? alu_out : d_q;
    pc_d = take ? a_tgt : (pc_q + PC_W'(1));
  end

  assign active   = ~reset & (state_q != S_HALT);
  assign readM    = active & is_c & a_bit;
  assign writeM   = active & is_c & instruction[3];
  assign stall    = ~reset & ((state_q == S_WAIT) |
                              ((state_q == S_RUN) & mem_req & ~mem_ack));
  assign outM     = alu_out;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      a_q      <= '0;
      d_q      <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (retire) begin
      a_q   <= a_d;
      d_q   <= d_d;
      pc_q  <= pc_d;
      cnt_q <= '0;
      if (self_jump) begin
        state_q  <= S_HALT;
        halted_q <= 1'b1;
      end else begin
        state_q <= S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_W'(1);
        end
        S_WAIT: begin
          if (cnt_q == CNT_MAX) begin
            state_q  <= S_HALT;
            fault_q  <= 1'b1;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HALT: ;
        default: state_q <= S_HALT;
      endcase
    end
  end

`ifdef HACK_CPU_PERF_EN
  logic [31:0] perf_retired_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else if (state_q != S_HALT) begin
      if (retire) perf_retired_q <= perf_retired_q + 32'd1;
      if (stall)  perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`else
  // Default build carries no performance counters.
`endif

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_wait.sv
// tb_hack_cpu_wait: directed vector table plus randomized run against a behavioural model.
`default_nettype none

module tb_hack_cpu_wait;
  localparam int WMAX = 4;

  logic        clk, reset, mem_ack;
  logic [15:0] instruction;
  logic [31:0] inM, outM;
  logic        writeM, readM, stall, halted, fault;
  logic [14:0] addressM, pc;
`ifdef HACK_CPU_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  hack_cpu_wait #(.DATA_W(32), .ADDR_W(15), .PC_W(15), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .inM(inM), .mem_ack(mem_ack),
    .outM(outM), .writeM(writeM), .readM(readM), .addressM(addressM), .pc(pc),
    .stall(stall), .halted(halted), .fault(fault)
`ifdef HACK_CPU_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    logic [15:0] ins;
    logic [31:0] inm;
    bit          ack;
    logic [14:0] pc;
    bit          st, rd, wr, hl, fl;
    logic [14:0] addr;
    logic [31:0] om;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic v(input bit r, input logic [15:0] ins, input logic [31:0] inm, input bit ack,
                   input logic [14:0] p, input bit st, input bit rd, input bit wr,
                   input bit hl, input bit fl, input logic [14:0] addr, input logic [31:0] om);
    vec_t e;
    e = '{r, ins, inm, ack, p, st, rd, wr, hl, fl, addr, om};
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input logic [15:0] ins, input logic [31:0] inm, input bit ack);
    reset = r; instruction = ins; inM = inm; mem_ack = ack;
  endtask

  // Reference model: architectural registers plus count of unacknowledged cycles.
  logic [31:0] mA, mD;
  logic [14:0] mpc;
  bit          mhalt, mflt;
  int          mwaits;

  function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y, input logic [5:0] c);
    logic [31:0] r;
    if (c[5]) x = 32'd0;
    if (c[4]) x = ~x;
    if (c[3]) y = 32'd0;
    if (c[2]) y = ~y;
    r = c[1] ? x + y : x & y;
    return c[0] ? ~r : r;
  endfunction

  task automatic model_reset();
    mA = 0; mD = 0; mpc = 0; mhalt = 0; mflt = 0; mwaits = 0;
  endtask

  task automatic model_step(input bit r, input logic [15:0] ins, input logic [31:0] inm, input bit ack);
    logic [31:0] res;
    logic [14:0] tgt;
    bit          isc, mem, neg, zero, taken;
    isc = ins[15];
    mem = isc && (ins[12] || ins[3]);
    if (r) begin
      model_reset();
    end else if (!mhalt) begin
      if (mem && !ack) begin
        if (mwaits == WMAX) begin mhalt = 1; mflt = 1; end
        else mwaits++;
      end else begin
        mwaits = 0;
        if (!isc) begin
          mA  = {17'd0, ins[14:0]};
          mpc = mpc + 15'd1;
        end else begin
          res   = alu(mD, ins[12] ? inm : mA, ins[11:6]);
          tgt   = mA[14:0];
          neg   = $signed(res) < 0;
          zero  = (res == 0);
          taken = (ins[2] && neg) || (ins[1] && zero) || (ins[0] && !neg && !zero);
          if (ins[2:0] == 3'b111 && tgt == mpc) mhalt = 1;
          if (ins[4]) mD = res;
          if (ins[5]) mA = res;
          mpc = taken ? tgt : mpc + 15'd1;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic [31:0] inm, eo;
    bit          r, ack, isc, mem, est, erd, ewr, prev_st;

    drive(1, 16'h0000, 0, 0);
    @(posedge clk); #1;

    v(1,16'hE308,0,0,        0,0,0,0,0,0, 0,0);
    v(0,16'h000F,0,0,        0,0,0,0,0,0, 0,0);
    v(0,16'hEC10,0,0,        1,0,0,0,0,0, 15,0);
    v(0,16'h0001,0,0,        2,0,0,0,0,0, 15,0);
    v(0,16'hE308,0,1,        3,0,0,1,0,0, 1,15);
    v(0,16'hFC10,32'h1234,0, 4,1,1,0,0,0, 1,0);
    v(0,16'hFC10,32'h1234,0, 4,1,1,0,0,0, 1,0);
    v(0,16'hFC10,32'h1234,0, 4,1,1,0,0,0, 1,0);
    v(0,16'hFC10,32'hABCD,1, 4,1,1,0,0,0, 1,0);
    v(0,16'hE308,0,1,        5,0,0,1,0,0, 1,32'hABCD);
    v(0,16'h0007,0,0,        6,0,0,0,0,0, 1,0);
    v(0,16'hEA87,0,0,        7,0,0,0,0,0, 7,0);
    v(0,16'h0003,0,0,        7,0,0,0,1,0, 7,0);
    v(0,16'hE308,0,0,        7,0,0,0,1,0, 7,0);
    v(1,16'hE308,0,0,        7,0,0,0,1,0, 7,0);
    for (int k = 0; k < 5; k++) v(0,16'hE308,0,0, 0,1,0,1,0,0, 0,0);
    v(0,16'hE308,0,1,        0,0,0,0,1,1, 0,0);
    v(1,16'h0000,0,0,        0,0,0,0,1,1, 0,0);
    v(0,16'h0014,0,0,        0,0,0,0,0,0, 0,0);
    v(0,16'hEE90,0,0,        1,0,0,0,0,0, 20,0);
    v(0,16'hE7D2,0,0,        2,0,0,0,0,0, 20,0);
    v(0,16'hE308,0,1,        20,0,0,1,0,0, 20,0);
    v(0,16'hFC10,0,0,        21,1,1,0,0,0, 20,0);
    v(1,16'hFC10,32'h5555,1, 21,0,0,0,0,0, 20,0);
    v(0,16'h0005,0,0,        0,0,0,0,0,0, 0,0);
    v(0,16'hE308,0,1,        1,0,0,1,0,0, 5,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].ins, tbl[i].inm, tbl[i].ack);
      @(negedge clk);
      nvec++;
      chk($sformatf("tbl%0d pc", i),     32'(pc),       32'(tbl[i].pc));
      chk($sformatf("tbl%0d addr", i),   32'(addressM), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d stall", i),  32'(stall),    32'(tbl[i].st));
      chk($sformatf("tbl%0d readM", i),  32'(readM),    32'(tbl[i].rd));
      chk($sformatf("tbl%0d writeM", i), 32'(writeM),   32'(tbl[i].wr));
      chk($sformatf("tbl%0d halted", i), 32'(halted),   32'(tbl[i].hl));
      chk($sformatf("tbl%0d fault", i),  32'(fault),    32'(tbl[i].fl));
      if (tbl[i].wr) chk($sformatf("tbl%0d outM", i), outM, tbl[i].om);
`ifdef HACK_CPU_PERF_EN
      if (i == 28) begin
        chk("perf_retired after reset", perf_retired, 32'd0);
        chk("perf_stall after reset", perf_stall, 32'd0);
      end
`endif
      @(posedge clk); #1;
    end

    drive(1, 16'h0000, 0, 0);
    @(posedge clk); #1;
    model_reset();
    prev_st = 0;
    ins = 16'h0000;

    for (int n = 0; n < 4000; n++) begin
      r = mhalt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      if (!prev_st) begin
        if ($urandom_range(0, 2) == 0) ins = {11'd0, 5'($urandom_range(0, 31))};
        else                           ins = 16'($urandom) | 16'h8000;
      end
      inm = $urandom;
      ack = ($urandom_range(0, 1) == 1);
      drive(r, ins, inm, ack);

      isc = ins[15];
      mem = isc && (ins[12] || ins[3]);
      erd = !r && !mhalt && isc && ins[12];
      ewr = !r && !mhalt && isc && ins[3];
      est = !r && !mhalt && mem && (mwaits > 0 || !ack);
      eo  = alu(mD, ins[12] ? inm : mA, ins[11:6]);

      @(negedge clk);
      nvec++;
      chk("rnd pc",     32'(pc),       32'(mpc));
      chk("rnd addr",   32'(addressM), 32'(mA[14:0]));
      chk("rnd stall",  32'(stall),    32'(est));
      chk("rnd readM",  32'(readM),    32'(erd));
      chk("rnd writeM", 32'(writeM),   32'(ewr));
      chk("rnd halted", 32'(halted),   32'(mhalt));
      chk("rnd fault",  32'(fault),    32'(mflt));
      if (ewr) chk("rnd outM", outM, eo);
      @(posedge clk); #1;
      model_step(r, ins, inm, ack);
      prev_st = est;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
